sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_starve_ctr.sv | 25 ++
 rtl/sram_arbiter.sv | 124 ++++++++++++
 tb/tb_sram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: FSM states, grant owner and the
// default starvation limit.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  localparam int MAX_STARVE_DEF = 4;

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Saturating counter of consecutive data-port wins taken while the
// instruction port was waiting. Clear has priority over increment.
module sram_arb_starve_ctr
  import sram_arb_pkg::*;
#(
  parameter int MAX   = MAX_STARVE_DEF,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count up to MAX and stick there until cleared.
  always_ff @(posedge HCLK) begin
    if (HRESET || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_W'(MAX))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of a single
// SRAM with one-cycle read latency. One access in flight at a time:
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE, data port wins ties unless the
// instruction port has been passed over MAX_STARVE times in a row.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic                  m_sel,
  output logic                  m_write,
  output logic [3:0]            m_be,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata,
  input  logic                  m_ready,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  state_t                  state;
  gnt_t                    gnt;
  logic                    lat_we;
  logic [3:0]              lat_be;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_wdata;
  logic [CNT_W-1:0]        starve_cnt;
  logic                    grant;
  logic                    pick_d;
  logic                    cnt_inc;
  logic                    cnt_clr;

  // Arbitration decision and starvation counter control for an IDLE grant.
  always_comb begin
    grant   = (state == IDLE) && (i_req || d_req);
    pick_d  = d_req && !(i_req && (starve_cnt == CNT_W'(MAX_STARVE)));
    cnt_inc = grant && pick_d && i_req;
    cnt_clr = grant && !cnt_inc;
  end

  sram_arb_starve_ctr #(
    .MAX   (MAX_STARVE),
    .CNT_W (CNT_W)
  ) u_starve (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (starve_cnt)
  );

  // Access sequencer: latch the winner's command, issue, wait for the SRAM,
  // then capture read data into the granted port's holding register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      gnt       <= GNT_I;
      lat_we    <= 1'b0;
      lat_be    <= 4'h0;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
      i_rdata   <= 32'h0;
      d_rdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= ISSUE;
            if (pick_d) begin
              gnt       <= GNT_D;
              lat_we    <= d_we;
              lat_be    <= d_be;
              lat_addr  <= d_addr;
              lat_wdata <= d_wdata;
            end else begin
              gnt       <= GNT_I;
              lat_we    <= 1'b0;
              lat_be    <= 4'hF;
              lat_addr  <= i_addr;
              lat_wdata <= 32'h0;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (m_ready) begin
            state <= RESP;
            if (gnt == GNT_D) d_rdata <= m_rdata;
            else              i_rdata <= m_rdata;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // SRAM strobes are live only in ISSUE; address/data hold the latched command.
  assign m_sel   = (state == ISSUE);
  assign m_write = (state == ISSUE) && lat_we;
  assign m_be    = (state == ISSUE) ? lat_be : 4'h0;
  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;

  assign i_ack = (state == RESP) && (gnt == GNT_I);
  assign d_ack = (state == RESP) && (gnt == GNT_D);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural one-cycle SRAM and an
// in-order scoreboard of expected (port, read data) completions.
module tb_sram_arbiter;

  logic        HCLK;
  logic        HRESET;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_sel;
  logic        m_write;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        busy;

  logic        preload;
  logic [31:0] mem [0:63];
  logic [5:0]  widx;

  typedef struct {
    logic        port_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  sram_arbiter dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .m_sel   (m_sel),
    .m_write (m_write),
    .m_be    (m_be),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .busy    (busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  assign widx = m_addr[7:2];

  // SRAM: ready and read data (old word) the cycle after a sampled select.
  always @(posedge HCLK) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h0BADF00D;
      mem[1]  <= 32'h01010101;
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'hAABBCCDD;
      m_ready <= 1'b0;
      m_rdata <= 32'h0;
    end else begin
      m_ready <= m_sel;
      if (m_sel) begin
        m_rdata <= mem[widx];
        if (m_write) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) mem[widx][8*b +: 8] <= m_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Completion monitor: every ack must match the next scoreboard entry.
  always @(negedge HCLK) begin
    if (!HRESET && !preload && (i_ack || d_ack)) begin
      exp_t e;
      chk("dual_ack", 32'(i_ack & d_ack), 32'h0);
      chk("sb_empty_on_ack", 32'(sb.size() == 0), 32'h0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_port", 32'(d_ack), 32'(e.port_d));
        chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic push_exp(input logic port_d, input logic [31:0] rd);
    exp_t e;
    e.port_d = port_d;
    e.rdata  = rd;
    sb.push_back(e);
  endtask

  // One isolated access started in cycle 0 with the arbiter IDLE.
  task automatic run_access(input logic use_d, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input string tag);
    push_exp(use_d, exp_rd);
    if (use_d) begin
      d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    chk({tag, "_c0_busy"}, 32'(busy), 32'h0);
    tick;
    chk({tag, "_c1_msel"}, 32'(m_sel), 32'h1);
    chk({tag, "_c1_mwrite"}, 32'(m_write), 32'(use_d & we));
    chk({tag, "_c1_mbe"}, 32'(m_be), use_d ? 32'(be) : 32'hF);
    chk({tag, "_c1_maddr"}, m_addr, addr);
    if (use_d && we) chk({tag, "_c1_mwdata"}, m_wdata, wdata);
    tick;
    chk({tag, "_c2_msel"}, 32'(m_sel), 32'h0);
    chk({tag, "_c2_acks"}, 32'({i_ack, d_ack}), 32'h0);
    tick;
    chk({tag, "_c3_ack"}, 32'({i_ack, d_ack}), use_d ? 32'h1 : 32'h2);
    tick;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk({tag, "_c4_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int d_seen, i_seen, nd, ni;
    logic [5:0] order;

    HRESET = 1'b1; preload = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    tick;
    tick;
    preload = 1'b0;
    tick;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'h0);
    chk("rst_msel", 32'(m_sel), 32'h0);
    chk("rst_maddr", m_addr, 32'h0);
    chk("rst_irdata", i_rdata, 32'h0);
    HRESET = 1'b0;
    tick;

    // Instruction fetch, store with partial byte enables, load back.
    run_access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, "iread");
    run_access(1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678, 32'hAABBCCDD, "store");
    chk("store_mem", mem[8], 32'hAABB5678);
    run_access(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'hAABB5678, "dload");

    // Tie: data first, instruction four cycles later.
    push_exp(1'b1, 32'h0BADF00D);
    push_exp(1'b0, 32'hDEADBEEF);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    i_req = 1'b1; i_addr = 32'h10;
    d_seen = -1; i_seen = -1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (d_ack) begin d_seen = k; d_req = 1'b0; end
      if (i_ack) begin i_seen = k; i_req = 1'b0; end
    end
    chk("tie_d_ack_cycle", d_seen, 32'd3);
    chk("tie_i_ack_cycle", i_seen, 32'd7);

    // Starvation: four data wins, then instruction, then data again.
    for (int n = 0; n < 4; n++) push_exp(1'b1, 32'h01010101);
    push_exp(1'b0, 32'hDEADBEEF);
    push_exp(1'b1, 32'h01010101);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    i_req = 1'b1; i_addr = 32'h10;
    nd = 0; ni = 0; order = 6'h0;
    for (int k = 1; k <= 24; k++) begin
      tick;
      if (k == 16) chk("starve_cnt_full", 32'(dut.starve_cnt), 32'd4);
      if (k == 17) chk("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);
      if (d_ack) begin
        order = {order[4:0], 1'b1};
        nd++;
        if (nd == 5) d_req = 1'b0;
      end
      if (i_ack) begin
        order = {order[4:0], 1'b0};
        ni++;
        i_req = 1'b0;
      end
    end
    chk("starve_order", 32'(order), 32'(6'b111101));
    chk("starve_d_count", nd, 32'd5);
    chk("starve_i_count", ni, 32'd1);

    // Reset while waiting on the SRAM: access abandoned, then re-issued.
    i_req = 1'b1; i_addr = 32'h10;
    tick;
    chk("rstw_c1_msel", 32'(m_sel), 32'h1);
    tick;
    chk("rstw_c2_busy", 32'(busy), 32'h1);
    HRESET = 1'b1;
    tick;
    chk("rstw_state", 32'(dut.state), 32'(sram_arb_pkg::IDLE));
    chk("rstw_busy", 32'(busy), 32'h0);
    chk("rstw_acks", 32'({i_ack, d_ack}), 32'h0);
    chk("rstw_mstrobes", 32'({m_sel, m_write, m_be}), 32'h0);
    chk("rstw_maddr", m_addr, 32'h0);
    chk("rstw_mwdata", m_wdata, 32'h0);
    chk("rstw_irdata", i_rdata, 32'h0);
    chk("rstw_drdata", d_rdata, 32'h0);
    HRESET = 1'b0;
    run_access(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, "reissue");

    tick;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
